// File: rtl/k_loop_if.sv
// Control/status bundle between the Mage control registers (master) and the
// kernel-loop controller (slave); cfg_addr also fans out to Pea.
interface k_loop_if #(
  parameter int N_CFG = 8,
  parameter int REP_W = 16
);
  localparam int CFG_W = (N_CFG > 1) ? $clog2(N_CFG) : 1;
  localparam int K_W   = $clog2(N_CFG + 1);

  logic             start;
  logic             abort;
  logic [K_W-1:0]   k;
  logic [REP_W-1:0] n_rep;
  logic             start_d;
  logic             busy;
  logic [CFG_W-1:0] cfg_addr;
  logic [REP_W-1:0] iter;
  logic             done;

  modport master (
    output start, abort, k, n_rep,
    input  start_d, busy, cfg_addr, iter, done
  );

  modport slave (
    input  start, abort, k, n_rep,
    output start_d, busy, cfg_addr, iter, done
  );
endinterface

// File: rtl/k_loop_controller.sv
// Kernel-loop controller for the Mage CGRA: delayed start pulse to Pea, then
// steps cfg_addr through K slots per iteration for n_rep iterations.
module k_loop_controller #(
  parameter int START_DELAY = 5,
  parameter int N_CFG       = 8,
  parameter int REP_W       = 16
) (
  input logic     clk_i,
  input logic     rst_i,
  k_loop_if.slave ctrl
);
  localparam int CFG_W = (N_CFG > 1) ? $clog2(N_CFG) : 1;
  localparam int K_W   = $clog2(N_CFG + 1);
  localparam int DLY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [CFG_W-1:0] k_last;
  logic [REP_W-1:0] n_last;
  logic [CFG_W-1:0] k_last_in;
  logic [REP_W-1:0] n_last_in;

  logic             start_d_q;
  logic             busy_q;
  logic [CFG_W-1:0] cfg_q;
  logic [REP_W-1:0] iter_q;
  logic             done_q;

  // Terminal indices (K-1, n_rep-1) are stored instead of the counts, so a
  // full-scale n_rep never needs a wider comparator and cannot overflow.
  always_comb begin
    k_last_in = '0;
    n_last_in = '0;
    if (ctrl.k == '0) begin
      k_last_in = '0;
    end else if (ctrl.k > K_W'(N_CFG)) begin
      k_last_in = CFG_W'(N_CFG - 1);
    end else begin
      k_last_in = CFG_W'(ctrl.k - K_W'(1));
    end
    if (ctrl.n_rep != '0) begin
      n_last_in = ctrl.n_rep - REP_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      k_last    <= '0;
      n_last    <= '0;
      start_d_q <= 1'b0;
      busy_q    <= 1'b0;
      cfg_q     <= '0;
      iter_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      start_d_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl.start && !ctrl.abort) begin
            k_last <= k_last_in;
            n_last <= n_last_in;
            busy_q <= 1'b1;
            cfg_q  <= '0;
            iter_q <= '0;
            if (START_DELAY == 1) begin
              state     <= RUN;
              start_d_q <= 1'b1;
            end else begin
              state   <= DELAY;
              dly_cnt <= DLY_W'(1);
            end
          end
        end

        // The accepting edge already counted as edge 1 of the delay.
        DELAY: begin
          if (ctrl.abort) begin
            state   <= IDLE;
            dly_cnt <= '0;
            busy_q  <= 1'b0;
            cfg_q   <= '0;
            iter_q  <= '0;
          end else if (dly_cnt == DLY_W'(START_DELAY - 1)) begin
            state     <= RUN;
            dly_cnt   <= '0;
            start_d_q <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end

        RUN: begin
          if (ctrl.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cfg_q  <= '0;
            iter_q <= '0;
          end else if (cfg_q == k_last) begin
            cfg_q <= '0;
            if (iter_q == n_last) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              iter_q <= '0;
            end else begin
              iter_q <= iter_q + REP_W'(1);
            end
          end else begin
            cfg_q <= cfg_q + CFG_W'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          cfg_q  <= '0;
          iter_q <= '0;
        end
      endcase
    end
  end

  assign ctrl.start_d  = start_d_q;
  assign ctrl.busy     = busy_q;
  assign ctrl.cfg_addr = cfg_q;
  assign ctrl.iter     = iter_q;
  assign ctrl.done     = done_q;
endmodule

// File: tb/tb_k_loop_controller.sv
// Directed bench: instance A (delay 5, 8 slots, 16-bit reps) and instance B
// (delay 1, 4 slots, 2-bit reps for full-scale repetition counts).
module tb_k_loop_controller;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  k_loop_if #(.N_CFG(8), .REP_W(16)) ia ();
  k_loop_if #(.N_CFG(4), .REP_W(2))  ib ();

  k_loop_controller #(.START_DELAY(5), .N_CFG(8), .REP_W(16)) dut_a (
    .clk_i(clk),
    .rst_i(rst),
    .ctrl (ia.slave)
  );

  k_loop_controller #(.START_DELAY(1), .N_CFG(4), .REP_W(2)) dut_b (
    .clk_i(clk),
    .rst_i(rst),
    .ctrl (ib.slave)
  );

  task automatic step;
    @(negedge clk);
  endtask

  // Packed as {start_d, busy, cfg_addr, iter, done}
  task automatic chk_a(input string tag, input logic sd, input logic bz,
                       input int cfg, input int it, input logic dn);
    logic [21:0] obs;
    logic [21:0] exp;
    obs = {ia.start_d, ia.busy, ia.cfg_addr, ia.iter, ia.done};
    exp = {sd, bz, 3'(cfg), 16'(it), dn};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic sd, input logic bz,
                       input int cfg, input int it, input logic dn);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {ib.start_d, ib.busy, ib.cfg_addr, ib.iter, ib.done};
    exp = {sd, bz, 2'(cfg), 2'(it), dn};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_a(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk_a(tag, 1'b0, 1'b0, 0, 0, 1'b0);
      step;
    end
  endtask

  task automatic start_a(input int k, input int n);
    ia.k     = 4'(k);
    ia.n_rep = 16'(n);
    ia.start = 1'b1;
    step;
    ia.start = 1'b0;
  endtask

  // Four DELAY cycles after the accepting edge; returns on the start_d cycle
  task automatic delay_a(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk_a(tag, 1'b0, 1'b1, 0, 0, 1'b0);
      step;
    end
  endtask

  task automatic start_b(input int k, input int n);
    ib.k     = 3'(k);
    ib.n_rep = 2'(n);
    ib.start = 1'b1;
    step;
    ib.start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    ia.start = 1'b0;
    ia.abort = 1'b0;
    ia.k     = '0;
    ia.n_rep = '0;
    ib.start = 1'b0;
    ib.abort = 1'b0;
    ib.k     = '0;
    ib.n_rep = '0;
    step;
    step;
    chk_a("reset_a", 1'b0, 1'b0, 0, 0, 1'b0);
    chk_b("reset_b", 1'b0, 1'b0, 0, 0, 1'b0);
    rst = 1'b0;
    step;

    // k=3, n_rep=2: start_d four cycles after acceptance, then 6 RUN cycles
    start_a(3, 2);
    delay_a("t2_delay");
    for (int i = 0; i < 6; i++) begin
      chk_a("t2_run", i == 0, 1'b1, i % 3, i / 3, 1'b0);
      step;
    end
    chk_a("t2_done", 1'b0, 1'b0, 0, 0, 1'b1);
    step;
    chk_a("t2_idle", 1'b0, 1'b0, 0, 0, 1'b0);

    // k=0, n_rep=0 behave as 1,1
    start_a(0, 0);
    delay_a("t3_k0_delay");
    chk_a("t3_k0_run", 1'b1, 1'b1, 0, 0, 1'b0);
    step;
    chk_a("t3_k0_done", 1'b0, 1'b0, 0, 0, 1'b1);
    step;

    // k=9 clamps to 8 slots
    start_a(9, 1);
    delay_a("t3_k9_delay");
    for (int i = 0; i < 8; i++) begin
      chk_a("t3_k9_run", i == 0, 1'b1, i, 0, 1'b0);
      step;
    end
    chk_a("t3_k9_done", 1'b0, 1'b0, 0, 0, 1'b1);
    step;

    // Abort in the 3rd DELAY cycle
    start_a(3, 2);
    chk_a("t4_d1", 1'b0, 1'b1, 0, 0, 1'b0);
    step;
    chk_a("t4_d2", 1'b0, 1'b1, 0, 0, 1'b0);
    step;
    chk_a("t4_d3", 1'b0, 1'b1, 0, 0, 1'b0);
    ia.abort = 1'b1;
    step;
    ia.abort = 1'b0;
    idle_a("t4_abort_delay", 4);

    // Abort in the last DELAY cycle suppresses start_d
    start_a(3, 2);
    for (int i = 0; i < 4; i++) begin
      chk_a("t4_last_delay", 1'b0, 1'b1, 0, 0, 1'b0);
      if (i == 3) ia.abort = 1'b1;
      step;
    end
    ia.abort = 1'b0;
    idle_a("t4_abort_last", 3);

    // Abort during RUN (iteration 1): no done afterwards
    start_a(3, 2);
    delay_a("t4_run_delay");
    for (int i = 0; i < 4; i++) begin
      chk_a("t4_run", i == 0, 1'b1, i % 3, i / 3, 1'b0);
      if (i == 3) ia.abort = 1'b1;
      step;
    end
    ia.abort = 1'b0;
    idle_a("t4_abort_run", 8);

    // Reset pulse during iteration 1 clears outputs without waiting for a clock
    start_a(2, 3);
    delay_a("t1_delay");
    for (int i = 0; i < 3; i++) begin
      chk_a("t1_run", i == 0, 1'b1, i % 2, i / 2, 1'b0);
      if (i < 2) step;
    end
    rst = 1'b1;
    #1;
    chk_a("t1_async_rst", 1'b0, 1'b0, 0, 0, 1'b0);
    step;
    rst = 1'b0;
    idle_a("t1_no_done", 8);

    // abort together with start in IDLE drops the start
    ia.k     = 4'd2;
    ia.n_rep = 16'd1;
    ia.start = 1'b1;
    ia.abort = 1'b1;
    step;
    ia.start = 1'b0;
    ia.abort = 1'b0;
    idle_a("t4_idle_abort", 3);

    // start held high: ignored while busy and in DONE, accepted right after
    ia.k     = 4'd2;
    ia.n_rep = 16'd1;
    ia.start = 1'b1;
    step;
    delay_a("t5_delay1");
    chk_a("t5_run1_0", 1'b1, 1'b1, 0, 0, 1'b0);
    step;
    chk_a("t5_run1_1", 1'b0, 1'b1, 1, 0, 1'b0);
    step;
    chk_a("t5_done1", 1'b0, 1'b0, 0, 0, 1'b1);
    step;
    chk_a("t5_gap", 1'b0, 1'b0, 0, 0, 1'b0);
    step;
    delay_a("t5_delay2");
    chk_a("t5_run2_0", 1'b1, 1'b1, 0, 0, 1'b0);
    step;
    chk_a("t5_run2_1", 1'b0, 1'b1, 1, 0, 1'b0);
    ia.start = 1'b0;
    step;
    chk_a("t5_done2", 1'b0, 1'b0, 0, 0, 1'b1);
    step;
    chk_a("t5_idle", 1'b0, 1'b0, 0, 0, 1'b0);

    // START_DELAY=1, back-to-back starts, k=2, n_rep=2
    ib.k     = 3'd2;
    ib.n_rep = 2'd2;
    ib.start = 1'b1;
    step;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) begin
        chk_b("t6_run", i == 0, 1'b1, i % 2, i / 2, 1'b0);
        if (rep == 1 && i == 0) ib.start = 1'b0;
        step;
      end
      chk_b("t6_done", 1'b0, 1'b0, 0, 0, 1'b1);
      step;
      chk_b("t6_gap", 1'b0, 1'b0, 0, 0, 1'b0);
      step;
    end

    // n_rep = 2**REP_W-1 terminates with iter reaching 2
    start_b(1, 3);
    for (int i = 0; i < 3; i++) begin
      chk_b("w_run", i == 0, 1'b1, 0, i, 1'b0);
      step;
    end
    chk_b("w_done", 1'b0, 1'b0, 0, 0, 1'b1);
    step;
    chk_b("w_idle", 1'b0, 1'b0, 0, 0, 1'b0);

    // k=5 clamps to 4 slots, n_rep=0 runs once
    start_b(5, 0);
    for (int i = 0; i < 4; i++) begin
      chk_b("b_clamp_run", i == 0, 1'b1, i, 0, 1'b0);
      step;
    end
    chk_b("b_clamp_done", 1'b0, 1'b0, 0, 0, 1'b1);
    step;
    chk_b("b_clamp_idle", 1'b0, 1'b0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
